uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, clock cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_AW, default 3, FIFO address width (depth = 2**FIFO_AW = 8 bytes).
REQ-003 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_data  input  8  byte to transmit.
REQ-006 SHALL have port wr_en  input  1  write strobe; one byte per high cycle.
REQ-007 SHALL have port full  output  1  FIFO holds 2**FIFO_AW bytes.
REQ-008 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-009 SHALL have port busy  output  1  high while FIFO is non-empty or a frame is in progress.
REQ-010 SHALL have port tx  output  1  serial line, idle high, LSB first.

Function
REQ-011 FIFO write SHALL occur at a rising edge with wr_en=1 and full=0; count increments the same edge.
REQ-012 wr_en=1 while full=1 SHALL drop the byte and assert overflow for exactly the next cycle, even if a pop occurs on the same edge.
REQ-013 Simultaneous write and pop on a non-full FIFO SHALL leave count unchanged and accept the written byte.
REQ-014 Read/write pointers SHALL be FIFO_AW bits wide and wrap modulo depth; count SHALL be FIFO_AW+1 bits wide.
REQ-015 Transmit FSM states: IDLE, START, DATA, PARITY (REQ-027 only), STOP.
REQ-016 IDLE with FIFO non-empty SHALL pop the head byte into an 8-bit shift register and enter START on the same edge; IDLE with FIFO empty SHALL stay in IDLE.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL send bits 0..7 LSB-first, each for CLKS_PER_BIT cycles, using a 3-bit bit index, then enter STOP (or PARITY).
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-020 Bit-period counter SHALL be 16 bits, restart at 0 on every state change, and advance the bit at count CLKS_PER_BIT-1.
REQ-021 tx SHALL be driven from a register (glitch-free); it SHALL be 1 in IDLE.
REQ-022 Latency: write at edge N into an empty FIFO with FSM in IDLE SHALL give tx=0 after edge N+2.
REQ-023 Back-to-back bytes SHALL be separated by exactly one IDLE cycle; frame period = 10*CLKS_PER_BIT+1 cycles.
REQ-024 busy SHALL be registered-equivalent to (state != IDLE) OR (count != 0).

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state IDLE, tx=1, full=0, overflow=0, busy=0, pointers, count and counters to 0; FIFO contents need not be cleared.
REQ-026 Reset mid-frame SHALL abort the frame immediately (tx=1) and discard all queued bytes; first frame after release follows REQ-022.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, SHALL insert PARITY state after DATA sending even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame period 11*CLKS_PER_BIT+1. Without it, no parity bit; PARITY state unreachable/absent.

Verification (CLKS_PER_BIT=4, FIFO_AW=3)
REQ-028 Reset released, write 0x41 once -> tx low after edge N+2, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, stop high 4 cycles, busy falls after frame (41 cycles total).
REQ-029 Write 0x55,0xAA on consecutive cycles -> two frames, second start bit begins exactly 41 cycles after first; with UART_TX_PARITY_EN parity bits 0,0 and spacing 45.
REQ-030 Write 10 bytes 0x00..0x09 in 10 consecutive cycles -> full high once 8 held (first byte popped after cycle 2), overflow pulses once for the dropped byte 0x09, received sequence 0x00..0x08.
REQ-031 Fill FIFO to full, then assert wr_en on the pop cycle -> byte dropped, overflow=1 for one cycle, count becomes 7.
REQ-032 Assert reset_n=0 during DATA bit 3 of 0xF0 with 3 bytes queued -> tx=1 asynchronously, busy=0, full=0; after release tx stays 1 with no frames sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an LSB-first UART transmitter (8N1).
// Define UART_TX_PARITY_EN to add an even-parity bit after the data (8E1).
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    // Transmitter state
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign full     = (count_q == FULL_CNT);
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign tx       = tx_q;

    assign push     = wr_en && !full;
    assign head     = mem_q[rptr_q];
    assign bit_done = (cnt_q == LAST_CNT);

    // FIFO data array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // FIFO pointer/count next state; a full FIFO drops the write
    // even when the transmitter pops on the same edge
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full;
        if (push) begin
            wptr_d = wptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM next state; bit counter restarts on every bit change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the current state, registered one cycle later
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and empties the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a UART-decoding scoreboard monitor.
// Expected bytes are queued at write time and popped per decoded frame.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB + 1;
`else
    localparam int FRAME = 10 * CPB + 1;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       tx;

    int n_cmp;
    int n_bad;
    int cyc;
    logic  mon_en;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .overflow(overflow),
        .busy(busy),
        .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input int lim);
        int j;
        j = 0;
        while (busy && j < lim) begin
            @(negedge clk);
            j++;
        end
        chk("drain", 32'(busy), 0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Monitor: decode frames from tx, compare against the scoreboard
    initial begin
        logic [7:0] rx;
        logic       par;
        logic [7:0] e;
        rx  = '0;
        par = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && tx === 1'b0) begin
                starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                chk("start_bit", 32'(tx), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = tx;
`endif
                repeat (CPB) @(negedge clk);
                chk("stop_bit", 32'(tx), 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_unexpected: got %02h expected none", rx);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", 32'(rx), 32'(e));
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", 32'(par), 32'(^e));
`endif
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int lows;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        mon_en  = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single byte: latency, frame length
        @(negedge clk);
        wr_data = 8'h41;
        wr_en   = 1'b1;
        exp_q.push_back(8'h41);
        @(negedge clk);
        wr_en = 1'b0;
        chk("lat_e0_tx", 32'(tx), 1);
        chk("busy_on_write", 32'(busy), 1);
        @(negedge clk);
        chk("lat_e1_tx", 32'(tx), 1);
        @(negedge clk);
        chk("lat_e2_tx", 32'(tx), 0);
        j = 3;
        while (busy && j < 200) begin
            @(negedge clk);
            j++;
        end
        chk("frame_cycles", 32'(j - 1), 32'(FRAME));
        repeat (2 * CPB) @(negedge clk);

        // Back-to-back bytes: start spacing
        starts.delete();
        wr_data = 8'h55;
        wr_en   = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        wr_data = 8'hAA;
        exp_q.push_back(8'hAA);
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(300);
        chk("start_count", 32'(starts.size()), 2);
        if (starts.size() >= 2) begin
            chk("start_spacing", 32'(starts[1] - starts[0]), 32'(FRAME));
        end

        // Ten writes in a row: fill, full, overflow on 0x09
        for (int k = 0; k < 10; k++) begin
            wr_en   = 1'b1;
            wr_data = k[7:0];
            if (k < 9) exp_q.push_back(k[7:0]);
            @(negedge clk);
            chk($sformatf("full_w%0d", k), 32'(full), 32'(k >= 8));
            chk($sformatf("ovf_w%0d", k), 32'(overflow), 32'(k == 9));
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_one_cycle", 32'(overflow), 0);
        chk("full_hold", 32'(full), 1);
        wait_idle(1000);

        // Full FIFO with a write on the pop edge
        wr_data = 8'h10;
        wr_en   = 1'b1;
        exp_q.push_back(8'h10);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'h10 + k[7:0];
            exp_q.push_back(8'h10 + k[7:0]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("fill_full", 32'(full), 1);
        repeat (FRAME + 1 - 10) @(negedge clk);
        chk("full_before_pop", 32'(full), 1);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        @(negedge clk);
        chk("pop_edge_ovf", 32'(overflow), 1);
        chk("pop_edge_cnt7", 32'(full), 0);
        wr_data = 8'h20;
        exp_q.push_back(8'h20);
        @(negedge clk);
        wr_en = 1'b0;
        chk("refill_full", 32'(full), 1);
        chk("pop_edge_ovf_end", 32'(overflow), 0);
        wait_idle(1000);

        // Reset during DATA bit 3 of 0xF0 with bytes queued
        mon_en  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hF0;
        @(negedge clk);
        wr_data = 8'h01;
        @(negedge clk);
        wr_data = 8'h02;
        @(negedge clk);
        wr_data = 8'h03;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (16) @(negedge clk);
        chk("f0_bit3_low", 32'(tx), 0);
        chk("busy_mid_frame", 32'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_ovf", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        lows    = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("quiet_after_reset", 32'(lows), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
